// File: rtl/dm_pkg.sv
// Shared definitions for the dm_responder data-memory slice: access size
// encodings, the responder FSM state type and the default geometry.
package dm_pkg;

    // Access size encodings carried on req_size (2'b11 is illegal).
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Responder FSM states.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dm_state_e;

    // Default storage depth in 32-bit words and default wait cycles.
    localparam int DM_DEFAULT_DEPTH   = 1024;
    localparam int DM_DEFAULT_LATENCY = 1;

    // Wait counter width; covers LATENCY up to 15.
    localparam int DM_CNT_W = 4;

endpackage

// File: rtl/dm_lane_align.sv
// Combinational lane logic for sub-word accesses: merges store data into the
// addressed byte lanes of the old word, and extracts/extends load data.
// Only instantiated when DM_SUBWORD_EN is defined.
module dm_lane_align
    import dm_pkg::*;
(
    input  logic [31:0] old_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        sign,
    output logic [31:0] merged_word,
    output logic [31:0] load_data
);

    logic [3:0]  lane_en;
    logic [31:0] wdata_rep;
    logic [31:0] shifted;

    // Byte-lane enables and store data replicated so every lane sees its slice.
    always_comb begin
        lane_en   = 4'b1111;
        wdata_rep = wdata;
        case (size)
            SZ_BYTE: begin
                lane_en   = 4'b0001 << addr_lo;
                wdata_rep = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                lane_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{wdata[15:0]}};
            end
            default: begin
                lane_en   = 4'b1111;
                wdata_rep = wdata;
            end
        endcase
    end

    // Per-lane merge: enabled lanes take new data, others keep the old byte.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign merged_word[gi*8 +: 8] = lane_en[gi] ? wdata_rep[gi*8 +: 8]
                                                    : old_word[gi*8 +: 8];
    end

    assign shifted = old_word >> {addr_lo, 3'b000};

    // Load extract: right-align the addressed lane(s), then sign/zero extend.
    always_comb begin
        case (size)
            SZ_BYTE: load_data = {{24{sign & shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_data = {{16{sign & shifted[15]}}, shifted[15:0]};
            default: load_data = old_word;
        endcase
    end

endmodule

// File: rtl/dm_responder.sv
// Single-port data-memory responder: accepts one CPU load/store at a time,
// waits LATENCY cycles, performs the access on the edge entering RESP and
// holds the response until the CPU takes it. Storage is cleared by reset.
// Optional feature macro: DM_SUBWORD_EN enables byte/half accesses; without
// it only aligned word accesses are legal.
module dm_responder
    import dm_pkg::*;
#(
    parameter int DEPTH   = DM_DEFAULT_DEPTH,
    parameter int LATENCY = DM_DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit NO_WAIT = (LATENCY == 0);
    localparam logic [DM_CNT_W-1:0] CNT_INIT =
        (LATENCY == 0) ? '0 : DM_CNT_W'(LATENCY - 1);

    dm_state_e state_reg, state_next;

    logic [DM_CNT_W-1:0] cnt_reg;
    logic                we_reg;
    logic [31:0]         addr_reg;
    logic [1:0]          size_reg;
    logic                sign_reg;
    logic [31:0]         wdata_reg;
    logic [31:0]         rsp_rdata_reg;
    logic                rsp_err_reg;

    logic [31:0] mem [DEPTH];

    logic          handshake;
    logic          access_now;
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [1:0]    acc_size;
    logic          acc_sign;
    logic [31:0]   acc_wdata;
    logic [AW-1:0] acc_idx;
    logic          acc_oob;
    logic          size_err;
    logic          acc_err;
    logic [31:0]   old_word;
    logic [31:0]   store_word;
    logic [31:0]   load_word;

    assign handshake = req_valid && (state_reg == ST_IDLE);

    // With no wait cycles the access uses the live request; otherwise the latched one.
    assign acc_we    = (state_reg == ST_IDLE) ? req_we    : we_reg;
    assign acc_addr  = (state_reg == ST_IDLE) ? req_addr  : addr_reg;
    assign acc_size  = (state_reg == ST_IDLE) ? req_size  : size_reg;
    assign acc_sign  = (state_reg == ST_IDLE) ? req_sign  : sign_reg;
    assign acc_wdata = (state_reg == ST_IDLE) ? req_wdata : wdata_reg;

    assign access_now = (handshake && NO_WAIT) ||
                        ((state_reg == ST_WAIT) && (cnt_reg == '0));

    // Out-of-range check uses the full word address, so there is no aliasing.
    assign acc_oob  = ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
    assign acc_idx  = acc_addr[2 +: AW];
    assign old_word = mem[acc_idx];

`ifdef DM_SUBWORD_EN
    assign size_err = (acc_size == 2'b11) ||
                      ((acc_size == SZ_HALF) && acc_addr[0]) ||
                      ((acc_size == SZ_WORD) && (acc_addr[1:0] != 2'b00));

    dm_lane_align u_lane_align (
        .old_word    (old_word),
        .wdata       (acc_wdata),
        .addr_lo     (acc_addr[1:0]),
        .size        (acc_size),
        .sign        (acc_sign),
        .merged_word (store_word),
        .load_data   (load_word)
    );
`else
    // Word-only build: any non-word size or misalignment is an error.
    assign size_err   = (acc_size != SZ_WORD) || (acc_addr[1:0] != 2'b00);
    assign store_word = acc_wdata;
    assign load_word  = old_word;

    logic unused_sign;
    assign unused_sign = acc_sign;
`endif

    assign acc_err = size_err || acc_oob;

    // FSM state register; reset wins over any simultaneous handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (req_valid) state_next = NO_WAIT ? ST_RESP : ST_WAIT;
            ST_WAIT: if (cnt_reg == '0) state_next = ST_RESP;
            ST_RESP: if (rsp_ready) state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs: ready only in IDLE, response presented only in RESP.
    always_comb begin
        req_ready = (state_reg == ST_IDLE);
        rsp_valid = (state_reg == ST_RESP);
    end

    // Request latch, wait counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_reg       <= '0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            size_reg      <= '0;
            sign_reg      <= 1'b0;
            wdata_reg     <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            if (handshake) begin
                we_reg    <= req_we;
                addr_reg  <= req_addr;
                size_reg  <= req_size;
                sign_reg  <= req_sign;
                wdata_reg <= req_wdata;
                cnt_reg   <= CNT_INIT;
            end else if ((state_reg == ST_WAIT) && (cnt_reg != '0)) begin
                cnt_reg <= cnt_reg - 1'b1;
            end
            if (access_now) begin
                rsp_rdata_reg <= (acc_err || acc_we) ? 32'd0 : load_word;
                rsp_err_reg   <= acc_err;
            end
        end
    end

    // Storage: cleared by reset, written only by a legal store on the access edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (access_now && acc_we && !acc_err) begin
            mem[acc_idx] <= store_word;
        end
    end

    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dm_responder.sv
// Scoreboard bench for dm_responder: expectations come from a byte-level
// reference model when a request is accepted and are checked when the
// response handshake occurs. A second instance (LATENCY=3) covers reset
// during the wait phase.
module tb_dm_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 1;
    localparam int LAT3  = 3;
`ifdef DM_SUBWORD_EN
    localparam bit SUBWORD = 1'b1;
`else
    localparam bit SUBWORD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset, reset3;
    logic        req_valid, req_valid3;
    logic        req_we, req_sign;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_ready, rsp_ready3;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        req_ready3, rsp_valid3, rsp_err3;
    logic [31:0] rsp_rdata3;

    always #5 clk = ~clk;

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_sign(req_sign), .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    dm_responder #(.DEPTH(DEPTH), .LATENCY(LAT3)) u_dut3 (
        .clk(clk), .reset(reset3), .req_valid(req_valid3), .req_ready(req_ready3),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_sign(req_sign), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
        .rsp_ready(rsp_ready3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [1:0]  size;
        logic [31:0] rdata;
        logic        err;
        int          acc_edge;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    int          n_checks = 0;
    int          n_errors = 0;
    int          edge_cnt = 0;
    logic        prev_valid = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference model: byte masks and shifts over a plain word array.
    function automatic exp_t model(input logic we, input logic [31:0] addr,
                                   input logic [1:0] size, input logic sign,
                                   input logic [31:0] wdata);
        exp_t        e;
        logic [31:0] w, v, mask;
        int          sh, idx;
        logic        bad;
        e.we = we; e.addr = addr; e.size = size;
        e.rdata = 32'd0; e.err = 1'b0; e.acc_edge = 0;
        bad = (size == 2'b11) || (size == 2'b01 && addr[0]) ||
              (size == 2'b10 && addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
        if (!SUBWORD && size != 2'b10) bad = 1'b1;
        if (bad) begin
            e.err = 1'b1;
            return e;
        end
        idx  = int'(addr[31:2]);
        sh   = 8 * int'(addr[1:0]);
        w    = model_mem[idx];
        mask = (size == 2'b00) ? 32'h0000_00FF :
               (size == 2'b01) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
        if (we) begin
            model_mem[idx] = (w & ~(mask << sh)) | ((wdata & mask) << sh);
        end else begin
            v = (w >> sh) & mask;
            if (sign && size == 2'b00 && v[7])  v = v | 32'hFFFF_FF00;
            if (sign && size == 2'b01 && v[15]) v = v | 32'hFFFF_0000;
            e.rdata = v;
        end
        return e;
    endfunction

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // Response monitor: latency on rise, hold stability, compare on handshake.
    always @(negedge clk) begin
        if (rsp_valid && !prev_valid) begin
            if (sb.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
            else                chk("latency", 32'(edge_cnt - sb[0].acc_edge), 32'(LAT));
        end
        if (rsp_valid && sb.size() != 0) begin
            if (rsp_ready) begin
                chk("rdata", rsp_rdata, sb[0].rdata);
                chk("err", {31'd0, rsp_err}, {31'd0, sb[0].err});
                chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                $display("txn %s addr=%h size=%0d rdata=%h err=%0d",
                         sb[0].we ? "store" : "load ", sb[0].addr, sb[0].size,
                         rsp_rdata, rsp_err);
                void'(sb.pop_front());
            end else begin
                chk("hold_rdata", rsp_rdata, sb[0].rdata);
                chk("hold_err", {31'd0, rsp_err}, {31'd0, sb[0].err});
                chk("hold_req_ready", {31'd0, req_ready}, 32'd0);
            end
        end
        prev_valid <= rsp_valid;
    end

    task automatic issue(input logic we, input logic [31:0] addr, input logic [1:0] size,
                         input logic sign, input logic [31:0] wdata);
        exp_t e;
        int   k;
        req_we = we; req_addr = addr; req_size = size; req_sign = sign; req_wdata = wdata;
        req_valid = 1'b1;
        k = 0;
        while (!req_ready && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
            return;
        end
        e = model(we, addr, size, sign, wdata);
        e.acc_edge = edge_cnt + 1;
        sb.push_back(e);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic txn(input logic we, input logic [31:0] addr, input logic [1:0] size,
                       input logic sign, input logic [31:0] wdata, input int hold);
        int k;
        rsp_ready = (hold == 0);
        issue(we, addr, size, sign, wdata);
        if (hold > 0) begin
            k = 0;
            while (!rsp_valid && k < 50) begin
                @(posedge clk); #1;
                k++;
            end
            repeat (hold) begin
                @(posedge clk); #1;
            end
            rsp_ready = 1'b1;
        end
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(posedge clk); #1;
            k++;
        end
        if (sb.size() != 0) begin
            chk("rsp_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'd0;
        reset = 1'b1; reset3 = 1'b1;
        req_valid = 1'b0; req_valid3 = 1'b0; rsp_ready = 1'b1; rsp_ready3 = 1'b1;
        req_we = 1'b0; req_addr = 32'd0; req_size = 2'b10; req_sign = 1'b0; req_wdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);

        // Word store/load, byte store and sub-word loads.
        txn(1'b1, 32'h10, 2'b10, 1'b0, 32'h1234_5678, 0);
        txn(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 0);
        txn(1'b1, 32'h11, 2'b00, 1'b0, 32'h0000_00AB, 0);
        txn(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h11, 2'b00, 1'b1, 32'd0, 0);
        txn(1'b0, 32'h11, 2'b00, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h12, 2'b01, 1'b1, 32'd0, 0);
        // Misaligned half, out-of-range store that must not alias word 0.
        txn(1'b0, 32'h13, 2'b01, 1'b0, 32'd0, 0);
        txn(1'b1, 32'h1000, 2'b10, 1'b0, 32'hCAFE_F00D, 0);
        txn(1'b0, 32'h1000, 2'b10, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h0, 2'b10, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h12, 2'b10, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h10, 2'b11, 1'b0, 32'd0, 0);
        // Response held for 5 cycles.
        txn(1'b0, 32'h10, 2'b10, 1'b0, 32'd0, 5);
        // Byte store to word 0, half store/load with sign.
        txn(1'b1, 32'h0, 2'b00, 1'b0, 32'h0000_0055, 0);
        txn(1'b0, 32'h0, 2'b10, 1'b0, 32'd0, 0);
        txn(1'b1, 32'h6, 2'b01, 1'b0, 32'h0000_8001, 0);
        txn(1'b0, 32'h6, 2'b01, 1'b1, 32'd0, 0);
        txn(1'b0, 32'h6, 2'b01, 1'b0, 32'd0, 0);
        txn(1'b0, 32'h4, 2'b10, 1'b0, 32'd0, 0);
        // Last in-range word.
        txn(1'b1, 32'hFFC, 2'b10, 1'b0, 32'hA5A5_5A5A, 0);
        txn(1'b0, 32'hFFC, 2'b10, 1'b0, 32'd0, 2);

        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            a = (i % 10 == 9) ? 32'h1000 + 32'($urandom_range(0, 15))
                              : 32'($urandom_range(0, 63));
            txn(1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), $urandom, $urandom_range(0, 2));
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        // LATENCY=3 instance: reset while waiting aborts the store.
        @(posedge clk); #1;
        reset3 = 1'b0;
        req_we = 1'b1; req_addr = 32'h20; req_size = 2'b10; req_sign = 1'b0;
        req_wdata = 32'hDEAD_BEEF; req_valid3 = 1'b1;
        chk("d3_ready_idle", {31'd0, req_ready3}, 32'd1);
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        chk("d3_ready_wait", {31'd0, req_ready3}, 32'd0);
        @(posedge clk); #1;
        reset3 = 1'b1;
        @(posedge clk); #1;
        reset3 = 1'b0;
        chk("d3_ready_after_rst", {31'd0, req_ready3}, 32'd1);
        chk("d3_valid_after_rst", {31'd0, rsp_valid3}, 32'd0);
        req_we = 1'b0; req_valid3 = 1'b1;
        @(posedge clk); #1;
        req_valid3 = 1'b0;
        k = 0;
        while (!rsp_valid3 && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        chk("d3_latency", 32'(k), 32'(LAT3));
        chk("d3_rdata", rsp_rdata3, 32'd0);
        chk("d3_err", {31'd0, rsp_err3}, 32'd0);
        $display("txn load  addr=%h size=2 rdata=%h err=%0d (latency-3 instance)",
                 32'h20, rsp_rdata3, rsp_err3);
        @(posedge clk); #1;
        chk("d3_valid_dropped", {31'd0, rsp_valid3}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
